// File: rtl/pend_req_arbiter.sv
// pend_req_arbiter: collects single-cycle request pulses into a pending
// register and offers one eligible (pending and unmasked) position at a time
// over a registered valid/ack handshake.
// Position vectors use big-endian numbering: position p (0 = leftmost bit)
// is reported downstream as index 15-p.
module pend_req_arbiter #(
   parameter int RR_MODE = 0,   // 0: lowest position wins, 1: round-robin after last ack
   parameter int NREQ    = 16   // request line count, only 16 is supported
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [0:15] req_set,
   input  logic [0:15] req_clr,
   input  logic [0:15] mask,
   input  logic        grant_ack,
   output logic        grant_vld,
   output logic [0:3]  grant_idx,
   output logic [0:15] pend,
   output logic        ovf
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   // Width is baked into the 4-bit index encoding; reject anything else early.
   generate
      if (NREQ != 16) begin : g_nreq_check
         $error("pend_req_arbiter: NREQ must be 16");
      end
      if (RR_MODE != 0 && RR_MODE != 1) begin : g_mode_check
         $error("pend_req_arbiter: RR_MODE must be 0 or 1");
      end
   endgenerate

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t      r_state;
   state_t      w_state_next;
   logic [0:15] r_pend;
   logic [0:15] w_pend_next;
   logic        r_vld;
   logic        w_vld_next;
   logic [3:0]  r_idx;          // encoded index 15-p of the current/last offer
   logic [3:0]  w_idx_next;
   logic [3:0]  r_last;         // position of the most recently acked grant
   logic [3:0]  w_last_next;
   logic        r_ovf;

   // ------------------------------------------------------------------
   // Per-position pending update
   // ------------------------------------------------------------------
   logic        w_offer;        // an offer is outstanding this cycle
   logic [3:0]  w_gpos;         // position of the outstanding offer
   logic [0:15] w_clr_ok;       // withdraw allowed for this position
   logic [0:15] w_ack_hit;      // this position is being acked now
   logic [0:15] w_ovf_hit;      // set landed on an already pending bit

   assign w_offer = (r_state == ST_OFFER);
   // 15-p for a 4-bit value is simply the bitwise complement.
   assign w_gpos  = ~r_idx;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_pend_bit
         // The offered bit is protected from withdraw; only ack may clear it.
         assign w_clr_ok[gi]    = req_clr[gi] & ~(w_offer & (w_gpos == 4'(gi)));
         assign w_ack_hit[gi]   = w_offer & grant_ack & (w_gpos == 4'(gi));
         // Set has the last word over both withdraw and ack.
         assign w_pend_next[gi] = req_set[gi] |
                                  (r_pend[gi] & ~w_clr_ok[gi] & ~w_ack_hit[gi]);
         // Re-arming the bit that is being acked is a legal refill, not an overflow.
         assign w_ovf_hit[gi]   = req_set[gi] & r_pend[gi] & ~w_ack_hit[gi];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Winner selection from the registered pending value
   // ------------------------------------------------------------------
   logic [0:15] w_elig;
   logic [3:0]  w_base;         // scan starts at w_base+1 and ends at w_base
   logic [3:0]  w_q;
   logic        w_found;
   logic [3:0]  w_sel;

   assign w_elig = r_pend & mask;
   // Fixed priority is round-robin with the pointer pinned at 15, so the
   // scan always begins at position 0.
   assign w_base = (RR_MODE != 0) ? r_last : 4'd15;

   // Scan the 16 positions in priority order and keep the first eligible one.
   always_comb begin
      w_found = 1'b0;
      w_sel   = 4'd0;
      w_q     = 4'd0;
      for (int k = 1; k <= 16; k++) begin
         w_q = w_base + 4'(k);   // wraps 15 -> 0 naturally in 4 bits
         if (!w_found && w_elig[w_q]) begin
            w_found = 1'b1;
            w_sel   = w_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // Offer FSM
   // ------------------------------------------------------------------
   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and next offer registers; the offer is frozen while in OFFER.
   always_comb begin
      w_state_next = r_state;
      w_vld_next   = r_vld;
      w_idx_next   = r_idx;
      w_last_next  = r_last;
      case (r_state)
         ST_IDLE: begin
            w_vld_next = 1'b0;
            if (w_found) begin
               w_state_next = ST_OFFER;
               w_vld_next   = 1'b1;
               w_idx_next   = ~w_sel;
            end
         end
         ST_OFFER: begin
            if (grant_ack) begin
               w_state_next = ST_IDLE;
               w_vld_next   = 1'b0;
               w_last_next  = w_gpos;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_vld_next   = 1'b0;
         end
      endcase
   end

   // Offer, pointer, pending and sticky overflow registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld  <= 1'b0;
         r_idx  <= 4'd0;
         r_last <= 4'd15;
         r_pend <= '0;
         r_ovf  <= 1'b0;
      end else begin
         r_vld  <= w_vld_next;
         r_idx  <= w_idx_next;
         r_last <= w_last_next;
         r_pend <= w_pend_next;
         r_ovf  <= r_ovf | (|w_ovf_hit);
      end
   end

   assign grant_vld = r_vld;
   assign grant_idx = r_idx;
   assign pend      = r_pend;
   assign ovf       = r_ovf;

endmodule
